adder_scheduler: RTL

Round-robin scheduler that shares one external 64-bit two-operand adder among up to four requesters. Each requester offers an operand pair over a valid/ready handshake. The scheduler grants one pair at a time, holds the operands stable on the adder inputs for a configurable number of cycles, and captures the sum. It returns the sum, tagged with the requester ID, over a valid/ready response channel. The block sits between the benchmark traffic sources and whichever adder implementation is under test, so adder variants can be swapped without touching the requesters.

---
 rtl/adder_sched_pkg.sv | 19 +
 rtl/adder_scheduler_rr_picker.sv | 33 +++
 rtl/adder_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types for the adder scheduler: FSM state, ID/counter widths,
// and a round-robin index helper.
package adder_sched_pkg;

  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Position k steps above p, wrapping at n.
  function automatic int wrap_idx(input int p, input int k, input int n);
    return (p + k) % n;
  endfunction

endpackage

// File: rtl/adder_scheduler_rr_picker.sv
// rr_picker: combinational round-robin picker. Searches upward from
// i_rr_ptr with wrap-around for the first set request bit.
//   i_req    : request vector (N_REQ bits)
//   i_rr_ptr : search start index
//   o_grant  : one-hot grant
//   o_idx    : binary grant index
//   o_any    : at least one request present
module rr_picker
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[wrap_idx(int'(i_rr_ptr), k, N_REQ)]) begin
        o_any = 1'b1;
        o_idx = ID_W'(wrap_idx(int'(i_rr_ptr), k, N_REQ));
        o_grant[wrap_idx(int'(i_rr_ptr), k, N_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin sharing of one external adder among up to
// four requesters. Grants one operand pair, holds it on add_sayi1/2 for
// ADD_CYCLES cycles, captures add_toplam and returns it tagged with the id.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_sayi1/
// req_sayi2 (requesters); add_sayi1/add_sayi2/add_toplam (external adder);
// resp_valid/resp_ready/resp_id/resp_toplam (response channel).
// Optional: define ADDER_SCHED_OVF_EN to add resp_ovf (unsigned carry-out).
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int N_REQ      = 4,
  parameter int ADD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_sayi1,
  input  logic [N_REQ*WIDTH-1:0] req_sayi2,
  output logic [WIDTH-1:0]       add_sayi1,
  output logic [WIDTH-1:0]       add_sayi2,
  input  logic [WIDTH-1:0]       add_toplam,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_toplam
`ifdef ADDER_SCHED_OVF_EN
  ,
  output logic                   resp_ovf
`endif
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_calc_end;
  logic [ID_W-1:0]    w_ptr_nxt;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Grant only ever covers valid bits, so ready implies the handshake.
  assign w_accept   = (r_state == IDLE) && w_any;
  assign w_calc_end = (r_state == CALC) && (r_cnt == '0);
  assign req_ready  = (r_state == IDLE) ? w_grant : '0;
  assign resp_valid = (r_state == DONE);
  assign resp_id    = r_id;

  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ?
                     '0 : w_idx + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_next = CALC;
      CALC:    if (r_cnt == '0) w_next = DONE;
      DONE:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_sayi1   <= '0;
      add_sayi2   <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      resp_toplam <= '0;
`ifdef ADDER_SCHED_OVF_EN
      resp_ovf    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        add_sayi1 <= req_sayi1[int'(w_idx)*WIDTH +: WIDTH];
        add_sayi2 <= req_sayi2[int'(w_idx)*WIDTH +: WIDTH];
        r_id      <= w_idx;
        r_rr_ptr  <= w_ptr_nxt;
        r_cnt     <= CNT_W'(ADD_CYCLES - 1);
      end else if (r_state == CALC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_calc_end) begin
        resp_toplam <= add_toplam;
`ifdef ADDER_SCHED_OVF_EN
        // A wrapped sum is smaller than either operand.
        resp_ovf    <= (add_toplam < add_sayi1);
`endif
      end
    end
  end

endmodule
